button_conditioner: RTL and testbench

Input front-end for the board's two active-low push buttons. It synchronises each raw pin to `clk`, debounces it with a per-channel state machine, and outputs a clean held level plus single-cycle press, release and long-press events. The LED sequencing control logic consumes these signals instead of the raw pins.

---
 rtl/button_conditioner.sv | 148 ++++++++++++++
 tb/tb_button_conditioner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Two-channel active-low button front end: 2-flop sync, per-channel debounce FSM, held level plus press/release/long strobes.
// Press/release accepted DEBOUNCE_CYCLES+2 edges after the pin is first sampled; all outputs registered, no backpressure.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int LONG_CYCLES     = 27_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_0,
  input  logic       button_1,
  output logic [1:0] pressed,
  output logic [1:0] press_pulse,
  output logic [1:0] release_pulse,
  output logic [1:0] long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  localparam logic [2:0] S_RELEASED     = 3'd0;
  localparam logic [2:0] S_PRESS_PEND   = 3'd1;
  localparam logic [2:0] S_PRESSED      = 3'd2;
  localparam logic [2:0] S_LONG_HELD    = 3'd3;
  localparam logic [2:0] S_RELEASE_PEND = 3'd4;

  logic [1:0] pins;
  assign pins = {button_1, button_0};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic          sync1, sync2, act;
    logic [2:0]    state, state_nxt;
    logic [DW-1:0] db_cnt, db_cnt_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          level_q, press_q, release_q, long_q;
    logic          db_done, press_nxt, release_nxt, long_nxt, level_nxt;

    assign act = ~sync2;

    // The stable-count compare anticipates the increment, so acceptance lands on the Nth differing cycle.
    assign db_done    = (act != level_q) && (db_cnt == DB_LAST);
    assign db_cnt_nxt = ((act == level_q) || db_done) ? '0 : db_cnt + DW'(1);

    always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      case (state)
        S_RELEASED: begin
          if (act) begin
            if (db_done) begin
              state_nxt = S_PRESSED;
              press_nxt = 1'b1;
              hold_nxt  = '0;
            end else begin
              state_nxt = S_PRESS_PEND;
            end
          end
        end
        S_PRESS_PEND: begin
          if (!act) begin
            state_nxt = S_RELEASED;
          end else if (db_done) begin
            state_nxt = S_PRESSED;
            press_nxt = 1'b1;
            hold_nxt  = '0;
          end
        end
        S_PRESSED: begin
          if (hold_cnt == HOLD_LAST) begin
            long_nxt  = 1'b1;
            hold_nxt  = HOLD_MAX;
            state_nxt = S_LONG_HELD;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_nxt = hold_cnt + HW'(1);
          end
          // A falling act overrides the LONG_HELD move; the long strobe still fires.
          if (!act) begin
            if (db_done) begin
              state_nxt   = S_RELEASED;
              release_nxt = 1'b1;
            end else begin
              state_nxt = S_RELEASE_PEND;
            end
          end
        end
        S_LONG_HELD: begin
          if (!act) begin
            if (db_done) begin
              state_nxt   = S_RELEASED;
              release_nxt = 1'b1;
            end else begin
              state_nxt = S_RELEASE_PEND;
            end
          end
        end
        S_RELEASE_PEND: begin
          // Hold count only reaches HOLD_MAX after the long strobe, so it identifies the origin state.
          if (act) begin
            state_nxt = (hold_cnt == HOLD_MAX) ? S_LONG_HELD : S_PRESSED;
          end else if (db_done) begin
            state_nxt   = S_RELEASED;
            release_nxt = 1'b1;
          end
        end
        default: state_nxt = S_RELEASED;
      endcase
    end

    assign level_nxt = (state_nxt == S_PRESSED) || (state_nxt == S_LONG_HELD) ||
                       (state_nxt == S_RELEASE_PEND);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1     <= 1'b1;
        sync2     <= 1'b1;
        state     <= S_RELEASED;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync1     <= pins[ch];
        sync2     <= sync1;
        state     <= state_nxt;
        db_cnt    <= db_cnt_nxt;
        hold_cnt  <= hold_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
      end
    end

    assign pressed[ch]       = level_q;
    assign press_pulse[ch]   = press_q;
    assign release_pulse[ch] = release_q;
    assign long_pulse[ch]    = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random pin activity, checked cycle by cycle against a run-length model.
module tb_button_conditioner;
  localparam int D = 4;
  localparam int L = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_0 = 1'b1;
  logic       button_1 = 1'b1;
  logic [1:0] pressed, press_pulse, release_pulse, long_pulse;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .button_0(button_0), .button_1(button_1),
    .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a level flips once act has disagreed with it for D consecutive cycles;
  // the hold time accrues only while held with no release pending.
  int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_hold[2], m_fired[2];
  int e_pp[2], e_rp[2], e_lp[2];
  int obs_pp[2], obs_rp[2], obs_lp[2], obs_held[2];
  int pp_edge[2], rp_edge[2], lp_edge[2];
  int edge_n = 0;

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_s1[ch] = 1; m_s2[ch] = 1; m_lvl[ch] = 0; m_run[ch] = 0;
      m_hold[ch] = 0; m_fired[ch] = 0;
      e_pp[ch] = 0; e_rp[ch] = 0; e_lp[ch] = 0;
    end
  endfunction

  function automatic void model_edge(input int pin0, input int pin1);
    int pin[2];
    pin[0] = pin0;
    pin[1] = pin1;
    for (int ch = 0; ch < 2; ch++) begin
      int act;
      act = 1 - m_s2[ch];
      e_pp[ch] = 0; e_rp[ch] = 0; e_lp[ch] = 0;
      if (m_lvl[ch] == 1 && m_run[ch] == 0 && m_fired[ch] == 0) begin
        m_hold[ch]++;
        if (m_hold[ch] == L) begin
          e_lp[ch] = 1;
          m_fired[ch] = 1;
        end
      end
      if (act != m_lvl[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == D) begin
          m_lvl[ch] = act;
          m_run[ch] = 0;
          if (act == 1) begin
            e_pp[ch] = 1; m_hold[ch] = 0; m_fired[ch] = 0;
          end else begin
            e_rp[ch] = 1;
          end
        end
      end else begin
        m_run[ch] = 0;
      end
      m_s2[ch] = m_s1[ch];
      m_s1[ch] = pin[ch];
    end
  endfunction

  function automatic void clear_obs();
    for (int ch = 0; ch < 2; ch++) begin
      obs_pp[ch] = 0; obs_rp[ch] = 0; obs_lp[ch] = 0; obs_held[ch] = 0;
      pp_edge[ch] = -1; rp_edge[ch] = -1; lp_edge[ch] = -1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (rst) model_reset();
    else model_edge(int'(button_0), int'(button_1));
    @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("pressed[%0d]", ch), int'(pressed[ch]), m_lvl[ch]);
      chk($sformatf("press_pulse[%0d]", ch), int'(press_pulse[ch]), e_pp[ch]);
      chk($sformatf("release_pulse[%0d]", ch), int'(release_pulse[ch]), e_rp[ch]);
      chk($sformatf("long_pulse[%0d]", ch), int'(long_pulse[ch]), e_lp[ch]);
      if (press_pulse[ch]) begin obs_pp[ch]++; pp_edge[ch] = edge_n; end
      if (release_pulse[ch]) begin obs_rp[ch]++; rp_edge[ch] = edge_n; end
      if (long_pulse[ch]) begin obs_lp[ch]++; lp_edge[ch] = edge_n; end
      if (pressed[ch]) obs_held[ch]++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pressed"}, int'(pressed), 0);
    chk({tag, "_press_pulse"}, int'(press_pulse), 0);
    chk({tag, "_release_pulse"}, int'(release_pulse), 0);
    chk({tag, "_long_pulse"}, int'(long_pulse), 0);
  endtask

  int base, base2;
  int rem[2];

  initial begin
    model_reset();
    clear_obs();
    // Reset with both pins held: outputs stay low, then re-press 6 edges after release.
    button_0 = 1'b0;
    button_1 = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    run(3);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("rst_repress_timing", int'(press_pulse), (k == 6) ? 3 : 0);
    end
    run(2);
    button_0 = 1'b1;
    button_1 = 1'b1;
    run(10);

    // Clean press/release on button_0.
    clear_obs();
    button_0 = 1'b0;
    base = edge_n;
    run(8);
    button_0 = 1'b1;
    base2 = edge_n;
    run(10);
    chk("clean_pp_count", obs_pp[0], 1);
    chk("clean_pp_latency", pp_edge[0] - base, 6);
    chk("clean_rp_latency", rp_edge[0] - base2, 6);
    chk("clean_lp_count", obs_lp[0], 0);
    chk("clean_ch1_quiet", obs_pp[1] + obs_rp[1] + obs_held[1], 0);

    // Glitch rejection on button_1.
    clear_obs();
    button_1 = 1'b0; run(3);
    button_1 = 1'b1; run(1);
    button_1 = 1'b0; run(3);
    button_1 = 1'b1; run(10);
    chk("glitch_strobes", obs_pp[1] + obs_rp[1] + obs_lp[1], 0);
    chk("glitch_held", obs_held[1], 0);

    // Long press with a short release bounce after the long strobe.
    clear_obs();
    button_0 = 1'b0;
    base = edge_n;
    run(18);
    button_0 = 1'b1; run(2);
    button_0 = 1'b0; run(4);
    button_0 = 1'b1;
    base2 = edge_n;
    run(12);
    chk("long_lp_count", obs_lp[0], 1);
    chk("long_lp_latency", lp_edge[0] - pp_edge[0], L);
    chk("long_rp_count", obs_rp[0], 1);
    chk("long_rp_latency", rp_edge[0] - base2, 6);

    // Both channels together; act drops on the same edge the hold completes.
    clear_obs();
    button_0 = 1'b0;
    button_1 = 1'b0;
    base = edge_n;
    run(13);
    button_0 = 1'b1;
    button_1 = 1'b1;
    run(12);
    chk("simul_pp_count", obs_pp[0] + obs_pp[1], 2);
    chk("simul_pp_same_edge", pp_edge[1], pp_edge[0]);
    chk("simul_lp_latency", lp_edge[0] - base, 16);
    chk("simul_lp_same_edge", lp_edge[1], lp_edge[0]);
    chk("simul_rp_count", obs_rp[0] + obs_rp[1], 2);

    // Reset while held: immediate clear, no release strobe, re-debounce afterwards.
    clear_obs();
    button_0 = 1'b0;
    run(8);
    chk("midrst_held_before", int'(pressed[0]), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst_async");
    model_reset();
    run(2);
    rst = 1'b0;
    base = edge_n;
    run(8);
    chk("midrst_rp_count", obs_rp[0], 0);
    chk("midrst_repress_latency", pp_edge[0] - base, 6);
    button_0 = 1'b1;
    run(10);

    // Random pin activity with occasional resets.
    rem[0] = 1;
    rem[1] = 1;
    for (int c = 0; c < 2000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        rem[ch]--;
        if (rem[ch] == 0) begin
          if (ch == 0) button_0 = ~button_0;
          else button_1 = ~button_1;
          rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 20))
                                                 : int'($urandom_range(1, 6));
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        chk_all_zero("rand_async_rst");
        model_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
